// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the round-robin I2C controller arbiter.
// The optional per-attempt timeout is enabled by defining I2C_ARB_TIMEOUT_EN.
package i2c_arb_pkg;

  localparam int unsigned I2C_XFER_W  = 24;
  localparam int unsigned ADDR_MSB    = 23;
  localparam int unsigned ADDR_LSB    = 16;
  localparam int unsigned REG_MSB     = 15;
  localparam int unsigned REG_LSB     = 8;
  localparam int unsigned PAYLOAD_MSB = 7;
  localparam int unsigned PAYLOAD_LSB = 0;
  localparam int unsigned RETRY_W     = 3;
  localparam int unsigned TMO_CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_RESP  = 3'd4
  } arb_state_e;

  // One controller transaction: {slave address, register, payload}
  typedef struct packed {
    logic [ADDR_MSB-ADDR_LSB:0]       addr;
    logic [REG_MSB-REG_LSB:0]         reg_addr;
    logic [PAYLOAD_MSB-PAYLOAD_LSB:0] payload;
  } i2c_xfer_t;

endpackage

// File: rtl/i2c_arbiter_if.sv
// Requester-side and controller-side signals of the I2C arbiter.
// master = arbiter side, slave = requesters plus controller.
interface i2c_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  import i2c_arb_pkg::*;

  logic [NUM_REQ-1:0]            req;
  logic [I2C_XFER_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            done;
  logic                          nack;
  logic                          timeout;
  logic                          ctl_start;
  i2c_xfer_t                     ctl_data;
  logic                          ctl_done;
  logic                          ctl_ack_n;

  modport master (
    input  req, req_data, ctl_done, ctl_ack_n,
    output grant, done, nack, timeout, ctl_start, ctl_data
  );

  modport slave (
    output req, req_data, ctl_done, ctl_ack_n,
    input  grant, done, nack, timeout, ctl_start, ctl_data
  );

endinterface

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first active request strictly after
// the last served index, wrapping at NUM_REQ-1 back to 0.
module i2c_rr_pick #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] win_c,
  output logic [IDX_W-1:0]   win_idx_c,
  output logic               valid_c
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] slot;

  always_comb begin
    win_c     = '0;
    win_idx_c = '0;
    valid_c   = 1'b0;
    slot      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      slot = {1'b0, last} + (IDX_W+1)'(off);
      if (slot >= NUM_REQ_W) slot = slot - NUM_REQ_W;
      if (!valid_c && req[slot[IDX_W-1:0]]) begin
        valid_c   = 1'b1;
        win_idx_c = slot[IDX_W-1:0];
      end
    end
    win_c[win_idx_c] = valid_c;
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C controller between NUM_REQ requesters,
// with NACK retry. Define I2C_ARB_TIMEOUT_EN for the per-attempt timeout.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clock_100khz,
  input  logic          reset,
  i2c_arbiter_if.master bus
);

  localparam int unsigned        IDX_W     = $clog2(NUM_REQ);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 nack_q, nack_d;
  logic                 ctl_start_q, ctl_start_d;
  i2c_xfer_t            ctl_data_q, ctl_data_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic                 expire_c;

  logic [NUM_REQ-1:0]   pick_win_c;
  logic [IDX_W-1:0]     pick_idx_c;
  logic                 pick_valid_c;
  i2c_xfer_t            req_xfer [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_xfer[g] = bus.req_data[g*I2C_XFER_W +: I2C_XFER_W];
  end

  i2c_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (bus.req),
    .last      (last_q),
    .win_c     (pick_win_c),
    .win_idx_c (pick_idx_c),
    .valid_c   (pick_valid_c)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;

  assign expire_c  = (cnt_q == TMO_CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_d = (state_q == ST_WAIT) && !bus.ctl_done && expire_c;

  // Attempt counter: zero in IDLE/GAP so every START begins at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE || state_q == ST_GAP)       cnt_d = '0;
    else if (state_q == ST_START || state_q == ST_WAIT) cnt_d = cnt_q + TMO_CNT_W'(1);
  end

  always_ff @(posedge clock_100khz) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire_c    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    last_d      = last_q;
    retry_d     = retry_q;
    ctl_data_d  = ctl_data_q;
    done_d      = '0;
    nack_d      = 1'b0;
    ctl_start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          grant_d    = pick_win_c;
          owner_d    = pick_idx_c;
          ctl_data_d = req_xfer[pick_idx_c];
          retry_d    = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        ctl_start_d = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        ctl_start_d = 1'b1;
        if (bus.ctl_done) begin
          ctl_start_d = 1'b0;
          if (!bus.ctl_ack_n) begin
            state_d = ST_RESP;
            done_d  = grant_q;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_GAP;
          end else begin
            state_d = ST_RESP;
            done_d  = grant_q;
            nack_d  = 1'b1;
          end
        end else if (expire_c) begin
          ctl_start_d = 1'b0;
          state_d     = ST_RESP;
          done_d      = grant_q;
          nack_d      = 1'b1;
        end
      end
      // GAP shows ctl_start low once; the following START cycle re-raises it.
      ST_GAP: begin
        ctl_start_d = 1'b1;
        state_d     = ST_START;
      end
      ST_RESP: begin
        grant_d = '0;
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer resets to NUM_REQ-1 so requester 0 is searched first.
  always_ff @(posedge clock_100khz) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      nack_q      <= 1'b0;
      ctl_start_q <= 1'b0;
      ctl_data_q  <= '0;
      retry_q     <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      owner_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      nack_q      <= nack_d;
      ctl_start_q <= ctl_start_d;
      ctl_data_q  <= ctl_data_d;
      retry_q     <= retry_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.nack      = nack_q;
  assign bus.ctl_start = ctl_start_q;
  assign bus.ctl_data  = ctl_data_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed plus randomized bench for i2c_arbiter with a round-robin reference model.
module tb_i2c_arbiter;
  import i2c_arb_pkg::*;

  localparam int NR = 3;
  localparam int MR = 3;
  localparam int TC = 40;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_arbiter_if #(.NUM_REQ(NR)) bus ();

  i2c_arbiter #(.NUM_REQ(NR), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TC)) dut (
    .clock_100khz (clk),
    .reset        (reset),
    .bus          (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_starts = 0;
  logic        prev_start = 1'b0;
  int          m_last;
  logic [23:0] data_a [NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.ctl_start === 1'b1 && prev_start !== 1'b1) n_starts++;
    prev_start = bus.ctl_start;
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference: first pending requester after the last served, wrapping.
  function automatic int model_pick(input logic [NR-1:0] m, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (m[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [23:0] d);
    if (v) data_a[i] = d;
    bus.req[i] = v;
    for (int k = 0; k < NR; k++) bus.req_data[k*24 +: 24] = data_a[k];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 32'(0));
    chk({tag, "_done"}, 32'(bus.done), 32'(0));
    chk({tag, "_nack"}, 32'(bus.nack), 32'(0));
    chk({tag, "_timeout"}, 32'(bus.timeout), 32'(0));
    chk({tag, "_ctl_start"}, 32'(bus.ctl_start), 32'(0));
    chk({tag, "_ctl_data"}, 32'(bus.ctl_data), 32'(0));
  endtask

  // One full transaction as seen by the controller; n_nack NACKs precede the ACK.
  task automatic run_xfer(input int owner, input int n_nack, input int lat,
                          input bit drop_mid, input bit keep_req);
    int          waitc;
    int          attempts;
    int          s0;
    logic        exp_nack;
    logic [23:0] exp_d;
    bit          held;
    waitc    = 0;
    exp_d    = data_a[owner];
    attempts = (n_nack > MR) ? MR + 1 : n_nack + 1;
    exp_nack = (n_nack > MR);
    while (bus.grant === '0 && waitc < 8) begin
      tick();
      waitc++;
    end
    chk("req_to_grant", 32'(waitc), 32'(1));
    chk("grant", 32'(bus.grant), 32'(oh(owner)));
    chk("ctl_data", 32'(bus.ctl_data), 32'(exp_d));
    chk("start_lo_in_start", 32'(bus.ctl_start), 32'(0));
    s0 = n_starts;
    for (int a = 0; a < attempts; a++) begin
      tick();
      chk("ctl_start_hi", 32'(bus.ctl_start), 32'(1));
      if (a > 0) begin
        chk("retry_grant", 32'(bus.grant), 32'(oh(owner)));
        tick();
      end
      if (a == 0 && drop_mid) bus.req[owner] = 1'b0;
      held = 1'b1;
      repeat (lat) begin
        tick();
        if (bus.ctl_start !== 1'b1 || bus.ctl_data !== exp_d || bus.done !== '0) held = 1'b0;
      end
      chk("hold_in_wait", 32'(held), 32'(1));
      bus.ctl_done  = 1'b1;
      bus.ctl_ack_n = (a < n_nack);
      tick();
      bus.ctl_done  = 1'b0;
      bus.ctl_ack_n = 1'b0;
      if (a < attempts - 1) chk("gap_lo", 32'(bus.ctl_start), 32'(0));
    end
    chk("done", 32'(bus.done), 32'(oh(owner)));
    chk("nack", 32'(bus.nack), 32'(exp_nack));
    chk("timeout", 32'(bus.timeout), 32'(0));
    chk("start_lo_resp", 32'(bus.ctl_start), 32'(0));
    chk("n_attempts", 32'(n_starts - s0), 32'(attempts));
    if (!keep_req) bus.req[owner] = 1'b0;
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'(0));
    chk("grant_clr", 32'(bus.grant), 32'(0));
    chk("start_lo_idle", 32'(bus.ctl_start), 32'(0));
    m_last = owner;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  owner;
    bit  quiet;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.ctl_done  = 1'b0;
    bus.ctl_ack_n = 1'b0;
    for (int k = 0; k < NR; k++) data_a[k] = '0;
    reset = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    reset  = 1'b0;
    m_last = NR - 1;
    tick();

    // Single request, ACK after 30 cycles
    set_req(0, 1'b1, 24'h724100);
    run_xfer(0, 0, 30, 1'b0, 1'b0);

    // Stray ctl_done while idle is ignored
    bus.ctl_done  = 1'b1;
    bus.ctl_ack_n = 1'b1;
    tick();
    bus.ctl_done  = 1'b0;
    bus.ctl_ack_n = 1'b0;
    tick();
    chk("stray_done", 32'(bus.done), 32'(0));
    chk("stray_grant", 32'(bus.grant), 32'(0));

    // Contention from reset: both held, order alternates 0,1,0,1
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    m_last = NR - 1;
    set_req(0, 1'b1, 24'h11AA01);
    set_req(1, 1'b1, 24'h22BB02);
    for (int t = 0; t < 4; t++) begin
      owner = model_pick(bus.req, m_last);
      run_xfer(owner, 0, 2 + t, 1'b0, 1'b1);
    end
    bus.req = '0;
    tick();

    // NACK twice then ACK; then NACK forever
    set_req(0, 1'b1, 24'($urandom));
    run_xfer(model_pick(bus.req, m_last), 2, 3, 1'b0, 1'b0);
    set_req(2, 1'b1, 24'($urandom));
    run_xfer(model_pick(bus.req, m_last), 9, 1, 1'b0, 1'b0);

    // Reset mid-WAIT aborts silently and restores requester-0 priority
    set_req(1, 1'b1, 24'h50A0B1);
    tick();
    tick();
    tick();
    chk("pre_reset_start", 32'(bus.ctl_start), 32'(1));
    reset = 1'b1;
    bus.req[1] = 1'b0;
    tick();
    reset  = 1'b0;
    m_last = NR - 1;
    chk_all_zero("mid_reset");
    tick();
    chk("post_reset_done", 32'(bus.done), 32'(0));
    set_req(0, 1'b1, 24'($urandom));
    set_req(1, 1'b1, 24'($urandom));
    run_xfer(model_pick(bus.req, m_last), 0, 2, 1'b0, 1'b0);
    run_xfer(model_pick(bus.req, m_last), 0, 2, 1'b0, 1'b0);

    // Withdrawn request still completes; no regrant afterwards
    set_req(1, 1'b1, 24'h3C0F5A);
    run_xfer(1, 0, 5, 1'b1, 1'b0);
    quiet = 1'b1;
    repeat (4) begin
      tick();
      if (bus.grant !== '0 || bus.done !== '0) quiet = 1'b0;
    end
    chk("withdrawn_no_regrant", 32'(quiet), 32'(1));

`ifdef I2C_ARB_TIMEOUT_EN
    begin
      int  c;
      bit  hi;
      set_req(2, 1'b1, 24'($urandom));
      owner = model_pick(bus.req, m_last);
      tick();
      chk("tmo_grant", 32'(bus.grant), 32'(oh(owner)));
      c  = 0;
      hi = 1'b1;
      while (bus.done === '0 && c < TC + 20) begin
        tick();
        c++;
        if (bus.done === '0 && c > 1 && bus.ctl_start !== 1'b1) hi = 1'b0;
      end
      chk("tmo_cycles", 32'(c), 32'(TC));
      chk("tmo_done", 32'(bus.done), 32'(oh(owner)));
      chk("tmo_nack", 32'(bus.nack), 32'(1));
      chk("tmo_flag", 32'(bus.timeout), 32'(1));
      chk("tmo_no_retry", 32'(hi), 32'(1));
      bus.req[owner] = 1'b0;
      m_last = owner;
      tick();
      chk("tmo_done_clr", 32'(bus.done), 32'(0));
    end
`endif

    // Randomized traffic against the round-robin model
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < NR; k++) begin
        if (!bus.req[k] && $urandom_range(1, 0) == 1) set_req(k, 1'b1, 24'($urandom));
      end
      if (bus.req == '0) set_req(int'($urandom_range(NR - 1, 0)), 1'b1, 24'($urandom));
      owner = model_pick(bus.req, m_last);
      run_xfer(owner, int'($urandom_range(5, 0)), int'($urandom_range(8, 0)),
               ($urandom_range(3, 0) == 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
